// File: rtl/declyr2.sv
// Fan-out layer res1 = z*w1 + b1, res2 = z*w2 + b2 in signed fixed point, sharing one multiplier.
// Optional macro DECLYR2_SATURATE_EN: saturate product narrowing and bias add instead of wrapping.
module declyr2 #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] res2,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready may depend combinationally on out_ready.

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    logic [WIDTH-1:0] z_r, w1_r, w2_r, b1_r, b2_r;

    logic [WIDTH-1:0]          wsel, bsel, mul_n, res_n;
    logic signed [2*WIDTH-1:0] prod, prod_sh;
    logic [WIDTH:0]            sum;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign dbg_state = state;

    // The single multiplier sees w1/b1 in MUL1 and w2/b2 in MUL2.
    assign wsel    = (state == MUL2) ? w2_r : w1_r;
    assign bsel    = (state == MUL2) ? b2_r : b1_r;
    assign prod    = $signed(z_r) * $signed(wsel);
    assign prod_sh = prod >>> FRAC;

    always_comb begin
        mul_n = prod_sh[WIDTH-1:0];
`ifdef DECLYR2_SATURATE_EN
        if (prod_sh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_sh[2*WIDTH-1]}})
            mul_n = prod_sh[2*WIDTH-1] ? SMIN : SMAX;
`endif
        sum   = {mul_n[WIDTH-1], mul_n} + {bsel[WIDTH-1], bsel};
        res_n = sum[WIDTH-1:0];
`ifdef DECLYR2_SATURATE_EN
        if (sum[WIDTH] != sum[WIDTH-1])
            res_n = sum[WIDTH] ? SMIN : SMAX;
`endif
    end

`ifndef DECLYR2_SATURATE_EN
    logic unused_bits;
    assign unused_bits = ^{prod_sh[2*WIDTH-1:WIDTH], sum[WIDTH]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res1      <= '0;
            res2      <= '0;
            z_r       <= '0;
            w1_r      <= '0;
            w2_r      <= '0;
            b1_r      <= '0;
            b2_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_r   <= z;
                        w1_r  <= w1;
                        w2_r  <= w2;
                        b1_r  <= b1;
                        b2_r  <= b2;
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    res1  <= res_n;
                    state <= MUL2;
                end
                MUL2: begin
                    res2      <= res_n;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            z_r   <= z;
                            w1_r  <= w1;
                            w2_r  <= w2;
                            b1_r  <= b1;
                            b2_r  <= b2;
                            state <= MUL1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/declyr2.md
DECLYR2 -- requirements
Module: declyr2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data, weight, bias and result width in signed two's complement.
REQ-002 The block SHALL have parameter FRAC, default 8, giving the fractional bit count of the fixed-point format (Q8.8 at defaults).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  z, w1, w2, b1 and b2 are valid.
REQ-006 in_ready  output  1  block accepts a transaction this cycle.
REQ-007 z  input  WIDTH  latent input sample.
REQ-008 w1, w2  input  WIDTH each  weights for output 1 and output 2.
REQ-009 b1, b2  input  WIDTH each  biases for output 1 and output 2.
REQ-010 out_valid  output  1  res1 and res2 are valid.
REQ-011 out_ready  input  1  downstream consumes results this cycle.
REQ-012 res1, res2  output  WIDTH each  registered results.

Function
REQ-013 The block SHALL compute the fan-out layer res1 = z*w1 + b1 and res2 = z*w2 + b2, time-multiplexing one WIDTH x WIDTH signed multiplier.
REQ-014 The multiply SHALL form the full 2*WIDTH signed product, arithmetic-shift it right by FRAC, and narrow the result to WIDTH bits (truncation toward negative infinity, no rounding).
REQ-015 The bias add SHALL be WIDTH-bit signed; overflow handling SHALL follow REQ-028/REQ-029.
REQ-016 The FSM SHALL have exactly four states: IDLE, MUL1, MUL2 and DONE.
REQ-017 A transaction SHALL be accepted on a rising edge where in_valid && in_ready, and all five operands SHALL be registered on that edge.
REQ-018 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); this combinational path from out_ready is intended.
REQ-019 Transitions: IDLE->MUL1 on accept; MUL1->MUL2 unconditionally, registering res1; MUL2->DONE unconditionally, registering res2.
REQ-020 Transitions from DONE: with out_ready && in_valid, go to MUL1 and accept the new transaction; with out_ready && !in_valid, go to IDLE; with !out_ready, stay in DONE.
REQ-021 out_valid SHALL be 1 exactly in DONE; at an accept on edge k, out_valid rises after edge k+2.
REQ-022 Sustained back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-023 res1 and res2 SHALL hold stable while out_valid && !out_ready.
REQ-024 res1 and res2 SHALL keep their last values after leaving DONE, with res1 updated only on the MUL1 edge and res2 only on the MUL2 edge.
REQ-025 Input changes outside the accept edge SHALL NOT affect an in-flight computation.

Reset
REQ-026 While rst is high, on each rising edge the block SHALL set state=IDLE, out_valid=0, res1=0, res2=0 and clear the operand registers; in_ready is then 1 after that edge.
REQ-027 Reset asserted in MUL1, MUL2 or DONE SHALL abort the transaction with no out_valid pulse, and a transaction presented in the same cycle as rst SHALL NOT be accepted.

Configuration
REQ-028 With macro DECLYR2_SATURATE_EN defined, the product narrowing and the bias add SHALL each saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (0x8000..0x7FFF at defaults).
REQ-029 Without DECLYR2_SATURATE_EN, the narrowing and the add SHALL wrap modulo 2^WIDTH, discarding upper bits.

Verification
REQ-030 Basic: z=0x0200, w1=0x0180, w2=0xFF00, b1=0x0100, b2=0x0080, out_ready=1 -> out_valid 2 edges after accept, res1=0x0400, res2=0xFE80.
REQ-031 Overflow: z=0x7F00, w1=0x0200, b1=0 -> res1=0xFE00 without the macro; res1=0x7FFF with DECLYR2_SATURATE_EN.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling inputs -> out_valid=1, res1/res2 stable, in_ready=0; out_ready=1 -> exactly one handshake.
REQ-033 Back-to-back: in_valid=1 continuously for 4 transactions with out_ready=1 -> 4 out_valid cycles spaced 3 cycles apart, results in order.
REQ-034 Reset in MUL2: assert rst for 1 cycle -> out_valid=0, res1=res2=0, in_ready=1 next cycle; no result emitted for the aborted transaction.
REQ-035 Negative operands: z=0xFF80, w1=0xFF80, b1=0 -> res1=0x0040; z=0xFF80, w2=0x0080, b2=0 -> res2=0xFFC0.
